// File: rtl/crossy_pkg.sv
// Shared types and constants for the game's collision/pickup path.
package crossy_pkg;

   localparam int unsigned PIX_W          = 6;
   localparam int unsigned COORD_W        = 10;
   localparam int unsigned CNT_W          = 8;
   localparam int unsigned SCORE_W        = 7;
   localparam int unsigned H_LAST_DEFAULT = 639;
   localparam int unsigned V_LAST_DEFAULT = 479;

   localparam logic [PIX_W-1:0] PIXEL_TRANSPARENT = 6'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2,
      EVAL = 2'd3
   } cm_state_t;

   // Score increment that sticks at max_score.
   function automatic logic [SCORE_W-1:0] score_sat_inc(
      input logic [SCORE_W-1:0] score,
      input logic [SCORE_W-1:0] max_score
   );
      return (score >= max_score) ? max_score : score + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-frame count of pixels where two sprite layers are both opaque.
module overlap_counter
   import crossy_pkg::*;
(
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [PIX_W-1:0] layer_a,
   input  logic [PIX_W-1:0] layer_b,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic hit_c;

   assign hit_c = (layer_a != PIXEL_TRANSPARENT) && (layer_b != PIXEL_TRANSPARENT);

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && hit_c && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/collision_monitor.sv
// Per-frame sprite overlap evaluation: car hits, money pickups, scores.
// Optional player-vs-player bump detection is built with COLLISION_P2P_EN.
module collision_monitor
   import crossy_pkg::*;
#(
   parameter int unsigned H_LAST        = H_LAST_DEFAULT,
   parameter int unsigned V_LAST        = V_LAST_DEFAULT,
   parameter int unsigned HIT_THRESHOLD = 4,
   parameter int unsigned MAX_SCORE     = 99
) (
   input  logic               Clk,
   input  logic               ResetN,
   input  logic               Active,
   input  logic               ClearScores,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [PIX_W-1:0]   P1Pixel,
   input  logic [PIX_W-1:0]   P2Pixel,
   input  logic [PIX_W-1:0]   CarPixel,
   input  logic [PIX_W-1:0]   MoneyPixel,
   input  logic               P1HitAck,
   input  logic               P2HitAck,
   output logic               P1Hit,
   output logic               P2Hit,
   output logic [1:0]         MoneyTaken,
   output logic [SCORE_W-1:0] P1Score,
   output logic [SCORE_W-1:0] P2Score,
   output logic               PlayerBump,
   output logic               FrameDone
);

   localparam logic [CNT_W-1:0]   HIT_TH = CNT_W'(HIT_THRESHOLD);
   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

   cm_state_t state, state_nxt;

   logic             at_origin_c, at_last_c;
   logic             cnt_clear, cnt_en;
   logic [CNT_W-1:0] c1_cnt, c2_cnt, m1_cnt, m2_cnt;

   assign at_origin_c = (DrawX == '0) && (DrawY == '0);
   assign at_last_c   = (DrawX == COORD_W'(H_LAST)) && (DrawY == COORD_W'(V_LAST));

   // Counting starts only on the frame origin, so partial frames never reach EVAL.
   assign cnt_clear = !Active || (state == EVAL);
   assign cnt_en    = Active && ((state == SCAN) || ((state == ARM) && at_origin_c));

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!Active) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (at_origin_c) state_nxt = SCAN;
            SCAN:    if (at_last_c)   state_nxt = EVAL;
            EVAL:    state_nxt = SCAN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   overlap_counter u_c1 (.Clk(Clk), .ResetN(ResetN), .layer_a(P1Pixel), .layer_b(CarPixel),
                         .clear(cnt_clear), .enable(cnt_en), .count(c1_cnt));
   overlap_counter u_c2 (.Clk(Clk), .ResetN(ResetN), .layer_a(P2Pixel), .layer_b(CarPixel),
                         .clear(cnt_clear), .enable(cnt_en), .count(c2_cnt));
   overlap_counter u_m1 (.Clk(Clk), .ResetN(ResetN), .layer_a(P1Pixel), .layer_b(MoneyPixel),
                         .clear(cnt_clear), .enable(cnt_en), .count(m1_cnt));
   overlap_counter u_m2 (.Clk(Clk), .ResetN(ResetN), .layer_a(P2Pixel), .layer_b(MoneyPixel),
                         .clear(cnt_clear), .enable(cnt_en), .count(m2_cnt));

   // Hit handshake, pickups and scores; a fresh hit in EVAL overrides a same-cycle ack.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         P1Hit      <= 1'b0;
         P2Hit      <= 1'b0;
         MoneyTaken <= '0;
         P1Score    <= '0;
         P2Score    <= '0;
         FrameDone  <= 1'b0;
      end else begin
         MoneyTaken <= '0;
         FrameDone  <= 1'b0;
         if (!Active) begin
            P1Hit <= 1'b0;
            P2Hit <= 1'b0;
         end else begin
            if (P1HitAck) P1Hit <= 1'b0;
            if (P2HitAck) P2Hit <= 1'b0;
            if (state == EVAL) begin
               FrameDone <= 1'b1;
               if (c1_cnt >= HIT_TH) begin
                  P1Hit <= 1'b1;
               end else if ((m1_cnt != '0) && !P1Hit) begin
                  MoneyTaken[0] <= 1'b1;
                  P1Score       <= score_sat_inc(P1Score, SCORE_MAX);
               end
               if (c2_cnt >= HIT_TH) begin
                  P2Hit <= 1'b1;
               end else if ((m2_cnt != '0) && !P2Hit) begin
                  MoneyTaken[1] <= 1'b1;
                  P2Score       <= score_sat_inc(P2Score, SCORE_MAX);
               end
            end
         end
         if (ClearScores) begin
            P1Score <= '0;
            P2Score <= '0;
         end
      end
   end

`ifdef COLLISION_P2P_EN
   logic [CNT_W-1:0] pb_cnt;

   overlap_counter u_pb (.Clk(Clk), .ResetN(ResetN), .layer_a(P1Pixel), .layer_b(P2Pixel),
                         .clear(cnt_clear), .enable(cnt_en), .count(pb_cnt));

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         PlayerBump <= 1'b0;
      end else if (!Active) begin
         PlayerBump <= 1'b0;
      end else if (state == EVAL) begin
         PlayerBump <= (pb_cnt != '0);
      end
   end
`else
   assign PlayerBump = 1'b0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Randomized raster stimulus against a per-frame counting model of the collision monitor.
module tb_collision_monitor;

   localparam int HL    = 19;
   localparam int VL    = 15;
   localparam int HTOT  = 24;
   localparam int VTOT  = 18;
   localparam int TH    = 4;
   localparam int MAXS  = 12;
   localparam int NPIX  = (HL + 1) * (VL + 1);
   localparam int NCYC  = 140 * HTOT * VTOT;
`ifdef COLLISION_P2P_EN
   localparam bit P2P = 1'b1;
`else
   localparam bit P2P = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       ResetN = 1'b0;
   logic       Active = 1'b0;
   logic       ClearScores = 1'b0;
   logic [9:0] DrawX = '0;
   logic [9:0] DrawY = '0;
   logic [5:0] P1Pixel = '0, P2Pixel = '0, CarPixel = '0, MoneyPixel = '0;
   logic       P1HitAck = 1'b0, P2HitAck = 1'b0;
   logic       P1Hit, P2Hit, PlayerBump, FrameDone;
   logic [1:0] MoneyTaken;
   logic [6:0] P1Score, P2Score;

   collision_monitor #(
      .H_LAST(HL), .V_LAST(VL), .HIT_THRESHOLD(TH), .MAX_SCORE(MAXS)
   ) dut (
      .Clk(Clk), .ResetN(ResetN), .Active(Active), .ClearScores(ClearScores),
      .DrawX(DrawX), .DrawY(DrawY),
      .P1Pixel(P1Pixel), .P2Pixel(P2Pixel), .CarPixel(CarPixel), .MoneyPixel(MoneyPixel),
      .P1HitAck(P1HitAck), .P2HitAck(P2HitAck),
      .P1Hit(P1Hit), .P2Hit(P2Hit), .MoneyTaken(MoneyTaken),
      .P1Score(P1Score), .P2Score(P2Score), .PlayerBump(PlayerBump), .FrameDone(FrameDone)
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: frame phase (0 idle, 1 waiting for origin, 2 counting, 3 evaluating) and plain counts.
   int m_phase;
   int k_c1, k_c2, k_m1, k_m2, k_pb;
   bit e_h1, e_h2, e_pb, e_fd;
   bit [1:0] e_mt;
   int e_s1, e_s2;

   // Frame plan: each layer is opaque over a linear run of active pixel indices.
   int st[4];
   int ln[4];
   int hx = 0, vy = 0;
   int drop = 0;
   bit started = 1'b0;

   task automatic check_val(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      k_c1 = 0; k_c2 = 0; k_m1 = 0; k_m2 = 0; k_pb = 0;
      e_h1 = 0; e_h2 = 0; e_pb = 0; e_fd = 0; e_mt = 0;
      e_s1 = 0; e_s2 = 0;
   endtask

   task automatic tally();
      bit n1 = (P1Pixel != 0);
      bit n2 = (P2Pixel != 0);
      bit nc = (CarPixel != 0);
      bit nm = (MoneyPixel != 0);
      k_c1 += int'(n1 && nc);
      k_c2 += int'(n2 && nc);
      k_m1 += int'(n1 && nm);
      k_m2 += int'(n2 && nm);
      k_pb += int'(n1 && n2);
   endtask

   task automatic model_update();
      bit at0  = (DrawX == 0) && (DrawY == 0);
      bit atl  = (int'(DrawX) == HL) && (int'(DrawY) == VL);
      bit h1 = e_h1, h2 = e_h2, bp = e_pb;
      int s1 = e_s1, s2 = e_s2;
      e_mt = 0;
      e_fd = 0;
      if (!Active) begin
         m_phase = 0;
         k_c1 = 0; k_c2 = 0; k_m1 = 0; k_m2 = 0; k_pb = 0;
         h1 = 0; h2 = 0; bp = 0;
      end else begin
         if (P1HitAck) h1 = 0;
         if (P2HitAck) h2 = 0;
         case (m_phase)
            0: m_phase = 1;
            1: if (at0) begin m_phase = 2; tally(); end
            2: begin tally(); if (atl) m_phase = 3; end
            default: begin
               e_fd = 1;
               if (k_c1 >= TH) h1 = 1;
               else if (k_m1 >= 1 && !e_h1) begin e_mt[0] = 1; s1 = (s1 < MAXS) ? s1 + 1 : MAXS; end
               if (k_c2 >= TH) h2 = 1;
               else if (k_m2 >= 1 && !e_h2) begin e_mt[1] = 1; s2 = (s2 < MAXS) ? s2 + 1 : MAXS; end
               bp = P2P && (k_pb >= 1);
               k_c1 = 0; k_c2 = 0; k_m1 = 0; k_m2 = 0; k_pb = 0;
               m_phase = 2;
            end
         endcase
      end
      if (ClearScores) begin s1 = 0; s2 = 0; end
      e_h1 = h1; e_h2 = h2; e_pb = bp; e_s1 = s1; e_s2 = s2;
   endtask

   task automatic compare_all();
      check_val("P1Hit",      int'(P1Hit),      int'(e_h1));
      check_val("P2Hit",      int'(P2Hit),      int'(e_h2));
      check_val("MoneyTaken", int'(MoneyTaken), int'(e_mt));
      check_val("P1Score",    int'(P1Score),    e_s1);
      check_val("P2Score",    int'(P2Score),    e_s2);
      check_val("PlayerBump", int'(PlayerBump), int'(e_pb));
      check_val("FrameDone",  int'(FrameDone),  int'(e_fd));
   endtask

   task automatic new_plan();
      for (int l = 0; l < 4; l++) begin
         st[l] = $urandom_range(0, NPIX - 1);
         ln[l] = $urandom_range(0, 6);
      end
      if ($urandom % 10 < 6) st[3] = st[0] + $urandom_range(0, 4);
      if ($urandom % 10 < 3) st[2] = st[0] + $urandom_range(0, 4);
      if ($urandom % 10 < 4) st[1] = st[3] + $urandom_range(0, 3);
      if ($urandom % 10 < 2) st[2] = st[1] + $urandom_range(0, 4);
      // Occasional frames with >255 overlaps: a wrapping counter would lose the event.
      if ($urandom % 12 == 0) begin
         if ($urandom % 2 == 0) begin
            st[1] = 0; ln[1] = 256 + $urandom_range(0, 2);
            st[2] = 0; ln[2] = NPIX;
            ln[0] = 0; ln[3] = 0;
         end else begin
            st[0] = 0; ln[0] = 256 + $urandom_range(0, 2);
            st[3] = 0; ln[3] = NPIX;
            ln[1] = 0; ln[2] = 0;
         end
      end
   endtask

   function automatic logic [5:0] layer_pix(input int l, input int idx, input bit act);
      if (act && idx >= st[l] && idx < st[l] + ln[l]) return 6'($urandom_range(1, 63));
      return 6'd0;
   endfunction

   task automatic drive_inputs();
      int  idx = vy * (HL + 1) + hx;
      bit  act = (hx <= HL) && (vy <= VL);
      if (hx == 0 && vy == 0) new_plan();
      if (!started && vy == 8) started = 1'b1;
      DrawX      = 10'(hx);
      DrawY      = 10'(vy);
      P1Pixel    = layer_pix(0, idx, act);
      P2Pixel    = layer_pix(1, idx, act);
      CarPixel   = layer_pix(2, idx, act);
      MoneyPixel = layer_pix(3, idx, act);
      if (drop > 0) begin
         Active = 1'b0;
         drop--;
      end else begin
         Active = started;
         if ($urandom % 3000 == 0) drop = $urandom_range(1, 500);
      end
      P1HitAck    = e_h1 ? ($urandom % 6 == 0) : ($urandom % 40 == 0);
      P2HitAck    = e_h2 ? ($urandom % 6 == 0) : ($urandom % 40 == 0);
      ClearScores = (m_phase == 3) ? ($urandom % 8 == 0) : ($urandom % 2000 == 0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      compare_all();
      ResetN = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc == 20000 || cyc == 41000) begin
            ResetN = 1'b0;
            #1;
            model_reset();
            compare_all();
         end
         if (cyc == 20003 || cyc == 41003) ResetN = 1'b1;
         drive_inputs();
         @(posedge Clk);
         if (!ResetN) model_reset();
         else         model_update();
         #1;
         compare_all();
         hx++;
         if (hx == HTOT) begin
            hx = 0;
            vy++;
            if (vy == VTOT) vy = 0;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/collision_monitor.md
# collision_monitor

Pixel-rate collision and pickup detector that sits downstream of the game layer outputs (player, car and money palette pixels). It counts per-frame overlaps between sprite layers, and latches player hit requests with an acknowledge handshake for the player blocks at each frame end. It also emits money-pickup pulses for the money spawners and keeps both players' scores.

## Interface
- `H_LAST`, 639, last active DrawX of a frame
- `V_LAST`, 479, last active DrawY of a frame
- `HIT_THRESHOLD`, 4, minimum overlapping pixels in one frame that count as a car hit
- `MAX_SCORE`, 99, score saturation value
- `Clk` in 1: pixel clock, the single clock
- `ResetN` in 1: asynchronous, active-low reset
- `Active` in 1: high while the game FSM is in Game
- `ClearScores` in 1: synchronous one-cycle pulse that zeroes both scores
- `DrawX`, `DrawY` in 10 each: current pixel coordinate
- `P1Pixel`, `P2Pixel`, `CarPixel`, `MoneyPixel` in 6 each: palette indices aligned to DrawX/DrawY in the same cycle; 0 = transparent
- `P1HitAck`, `P2HitAck` in 1: player block has respawned
- `P1Hit`, `P2Hit` out 1: level hit request, held until acknowledged
- `MoneyTaken` out 2: one-cycle pulse, bit0 = P1 grabbed, bit1 = P2 grabbed
- `P1Score`, `P2Score` out 7: saturating scores
- `PlayerBump` out 1: players overlapped last frame
- `FrameDone` out 1: one-cycle pulse per evaluated frame

## Operation
- FSM states are IDLE, ARM, SCAN and EVAL. Reset enters IDLE.
- IDLE → ARM when Active=1.
- ARM → SCAN on the cycle where DrawX=0 and DrawY=0; that pixel is counted. Partial frames are never evaluated.
- SCAN: every cycle, each saturating 8-bit overlap counter increments when both of its layers are non-zero:
  - c1 = P1 & Car
  - c2 = P2 & Car
  - m1 = P1 & Money
  - m2 = P2 & Money
  - pb = P1 & P2
- SCAN → EVAL after the cycle with DrawX=H_LAST and DrawY=V_LAST; that pixel is counted.
- EVAL takes one cycle, then returns to SCAN with all counters cleared.
- EVAL rules, per player n:
  - Hit: if cn ≥ HIT_THRESHOLD, set PnHit.
  - Grab: else if mn ≥ 1 and PnHit=0, pulse MoneyTaken[n] and increment the score, saturating at MAX_SCORE.
  - A hit in the same frame as a grab suppresses the grab.
  - A player with a pending hit cannot score.
  - FrameDone pulses.
- Handshake: PnHit clears on the cycle after PnHitAck is sampled high. If the ack and a new hit land in the same EVAL cycle, the hit wins and PnHit stays 1. An ack while PnHit=0 is ignored.
- Active=0 in any state: go to IDLE next cycle, clear the counters, P1Hit, P2Hit and PlayerBump. Scores are held.
- ClearScores has priority over an EVAL increment in the same cycle.
- Reset values: all outputs 0, counters 0, state IDLE.

## Timing
- Latency from the last counted pixel to outputs is 1 cycle: EVAL registers the outputs, visible in the following cycle.
- MoneyTaken and FrameDone are exactly one cycle wide.
- Scores update in the same cycle as MoneyTaken.
- Counter saturation at 255 is required; a wrap is a bug.

## Configuration
- `COLLISION_P2P_EN` defined: the pb counter exists, and PlayerBump is set in EVAL when pb ≥ 1, otherwise cleared in EVAL.
- Undefined: the pb counter is not built and PlayerBump is tied 0.
- All other behaviour is identical either way.

## Structure
- Shared package `crossy_pkg` holds:
  - the `cm_state_t` enum (IDLE, ARM, SCAN, EVAL)
  - `PIXEL_TRANSPARENT` = 6'd0
  - default `H_LAST`/`V_LAST` constants
- One sub-module, `overlap_counter`: two 6-bit layer inputs, clear, enable, saturating 8-bit count. Instantiated 4 times, or 5 with `COLLISION_P2P_EN`.

## Test plan
- Reset mid-SCAN with P1Hit=1 and P1Score=5 → all outputs 0 immediately, state IDLE, next counted frame begins only at (0,0).
- Active raised at DrawY=200, P1 & Car overlap of 10 pixels at rows 100 and 300 of the first partial frame → no P1Hit. The same overlap in the next full frame → P1Hit=1 one cycle after (639,479).
- P2 & Car overlap of exactly 3 pixels → no hit; 4 pixels → P2Hit set; P2HitAck held one cycle → P2Hit clears next cycle.
- P1 & Money overlap of 1 pixel, P1Score=98, over two consecutive frames → MoneyTaken=2'b01 pulse each frame, score 99 then stays 99.
- P1 grab and P1 car hit (5 pixels) in the same frame → P1Hit=1, no MoneyTaken, score unchanged; ClearScores coincident with a P2 grab → P2Score=0.
- `COLLISION_P2P_EN` defined, P1 & P2 overlap of 1 pixel → PlayerBump=1 after EVAL, cleared after the next clean frame. Undefined → PlayerBump stays 0.
